// File: rtl/mult_tdm_scheduler_if.sv
// Bundles the request/response side and the multiplier side of the TDM scheduler.
// Latency: none; this file only declares wires and their directions.
// Backpressure: req_ready per requester; the multiplier side has no stall.
//
// Ports (slave = scheduler view):
//   req_valid/req_ready, req_multiplier/req_multiplicand (packed, i at [i*WIDTH +: WIDTH])
//   resp_valid (one-hot pulse), resp_product
//   mult_start, mult_multiplier, mult_multiplicand -> multiplier
//   mult_product, mult_productDone                 <- multiplier
//   err_overrun (sticky)
interface mult_tdm_scheduler_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_multiplier;
  logic [NUM_REQ*WIDTH-1:0] req_multiplicand;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_multiplier;
  logic [WIDTH-1:0]         mult_multiplicand;
  logic [2*WIDTH-1:0]       mult_product;
  logic                     mult_productDone;
  logic                     err_overrun;

  modport slave (
    input  req_valid, req_multiplier, req_multiplicand, mult_product, mult_productDone,
    output req_ready, resp_valid, resp_product, mult_start, mult_multiplier,
           mult_multiplicand, err_overrun
  );

  modport master (
    output req_valid, req_multiplier, req_multiplicand, mult_product, mult_productDone,
    input  req_ready, resp_valid, resp_product, mult_start, mult_multiplier,
           mult_multiplicand, err_overrun
  );
endinterface

// File: rtl/mult_tdm_scheduler.sv
// Time-division scheduler sharing one sequential multiplier among NUM_REQ requesters.
// Latency: response exactly SLOT_CYCLES cycles after the owner's slot-start cycle.
// Backpressure: one-entry buffer per requester; req_ready low while that buffer is full.
//
// Ports: clk, rst (synchronous, active-high); bus = mult_tdm_scheduler_if.slave.
// A multiply is started at every slot start (dummy 0x0 if the owner has nothing
// buffered), so multiplier activity and response timing never depend on traffic.
module mult_tdm_scheduler #(
  parameter int WIDTH       = 8,
  parameter int NUM_REQ     = 2,
  parameter int SLOT_CYCLES = 12
) (
  input logic                  clk,
  input logic                  rst,
  mult_tdm_scheduler_if.slave  bus
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
  localparam logic [OW-1:0] LAST_OWNR = OW'(NUM_REQ - 1);

  logic [CW-1:0]      slot_cnt;
  logic [OW-1:0]      owner;
  logic [NUM_REQ-1:0] buf_full;
  logic [WIDTH-1:0]   buf_a [NUM_REQ];
  logic [WIDTH-1:0]   buf_b [NUM_REQ];
  logic               active;
  logic               done_seen;
  logic [2*WIDTH-1:0] capture;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [2*WIDTH-1:0] resp_product_q;
  logic               err_q;

  logic               slot_first;
  logic               slot_last;
  logic               issue_full;
  logic [WIDTH-1:0]   issue_a;
  logic [WIDTH-1:0]   issue_b;
  logic               done_hit;
  logic               final_ok;
  logic [2*WIDTH-1:0] final_product;

  always_comb begin
    slot_first = (slot_cnt == '0);
    slot_last  = (slot_cnt == LAST_CNT);
    issue_full = buf_full[owner];
    issue_a    = issue_full ? buf_a[owner] : '0;
    issue_b    = issue_full ? buf_b[owner] : '0;
    // A done in cycle 0 belongs to the previous slot's operation; ignore it.
    done_hit   = active && !slot_first && bus.mult_productDone && !done_seen;
    // A done arriving in the very last cycle is still honoured via bypass.
    final_ok      = done_seen || done_hit;
    final_product = done_seen ? capture : (done_hit ? bus.mult_product : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt       <= '0;
      owner          <= '0;
      buf_full       <= '0;
      active         <= 1'b0;
      done_seen      <= 1'b0;
      capture        <= '0;
      op_a           <= '0;
      op_b           <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else begin
      if (slot_last) begin
        slot_cnt <= '0;
        owner    <= (owner == LAST_OWNR) ? '0 : owner + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && !buf_full[i]) begin
          buf_full[i] <= 1'b1;
          buf_a[i]    <= bus.req_multiplier[i*WIDTH +: WIDTH];
          buf_b[i]    <= bus.req_multiplicand[i*WIDTH +: WIDTH];
        end
      end

      // Operands are frozen for the rest of the slot; buffer state sampled
      // here means a request landing at this same edge waits a full rotation.
      if (slot_first) begin
        op_a   <= issue_a;
        op_b   <= issue_b;
        active <= issue_full;
      end

      if (done_hit) begin
        capture   <= bus.mult_product;
        done_seen <= 1'b1;
      end

      resp_valid_q   <= '0;
      resp_product_q <= '0;
      if (slot_last && active) begin
        resp_valid_q[owner] <= 1'b1;
        resp_product_q      <= final_product;
        if (!final_ok) err_q <= 1'b1;
        buf_full[owner]     <= 1'b0;
        active              <= 1'b0;
        done_seen           <= 1'b0;
        capture             <= '0;
      end
    end
  end

  assign bus.req_ready         = ~buf_full;
  assign bus.mult_start        = slot_first && !rst;
  assign bus.mult_multiplier   = slot_first ? issue_a : op_a;
  assign bus.mult_multiplicand = slot_first ? issue_b : op_b;
  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_product      = resp_product_q;
  assign bus.err_overrun       = err_q;
endmodule

// File: tb/tb_mult_tdm_scheduler.sv
// Bench for mult_tdm_scheduler: directed scenarios plus random traffic.
// Reference model: per-requester service slot computed arithmetically from the rotation.
// A behavioural multiplier with fixed latency (and an extra stale done) closes the loop.
module tb_mult_tdm_scheduler;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 2;
  localparam int SC      = 12;
  localparam int LAT     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_tdm_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  mult_tdm_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SLOT_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int id;
    int prod;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   op_a_exp[int];
  int   op_b_exp[int];
  int   acc_cyc[NUM_REQ];
  int   busy_until[NUM_REQ];
  int   err_from;
  int   drop_slot;
  int   cyc = 0;
  logic rst_q = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    rst_q <= rst;
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Behavioural multiplier: done LAT cycles after start, then a second pulse
  // carrying a wrong product that the scheduler must ignore.
  int               mcnt  = 0;
  logic             mdrop = 1'b0;
  logic [WIDTH-1:0] ma    = '0;
  logic [WIDTH-1:0] mb    = '0;
  logic [2*WIDTH-1:0] mprod;

  always @(posedge clk) begin
    if (rst) begin
      mcnt  <= 0;
      mdrop <= 1'b0;
    end else if (bus.mult_start) begin
      ma    <= bus.mult_multiplier;
      mb    <= bus.mult_multiplicand;
      mcnt  <= 1;
      mdrop <= (cyc == drop_slot);
    end else if (mcnt != 0) begin
      mcnt <= (mcnt == LAT + 1) ? 0 : mcnt + 1;
    end
  end

  assign mprod                = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
  assign bus.mult_productDone = !mdrop && (mcnt == LAT || mcnt == LAT + 1);
  assign bus.mult_product     = (mcnt == LAT) ? mprod : ~mprod;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit model_ready(int i, int c);
    return !(acc_cyc[i] < c && c < busy_until[i]);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    op_a_exp.delete();
    op_b_exp.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_cyc[i]    = -1;
      busy_until[i] = 0;
    end
    err_from  = 1 << 30;
    drop_slot = -1;
  endtask

  task automatic clear_inputs();
    bus.req_valid        = '0;
    bus.req_multiplier   = (NUM_REQ*WIDTH)'($urandom);
    bus.req_multiplicand = (NUM_REQ*WIDTH)'($urandom);
  endtask

  // Offer a request in the current cycle; the model decides whether it is taken.
  task automatic offer(input int i, input int a, input int b);
    int k;
    int svc;
    exp_t e;
    bus.req_valid[i]                     = 1'b1;
    bus.req_multiplier[i*WIDTH +: WIDTH]   = WIDTH'(a);
    bus.req_multiplicand[i*WIDTH +: WIDTH] = WIDTH'(b);
    if (model_ready(i, cyc)) begin
      k = cyc / SC + 1;
      while (k % NUM_REQ != i) k++;
      svc = k * SC;
      e.id   = i;
      e.cyc  = svc + SC;
      e.prod = (svc == drop_slot) ? 0 : a * b;
      if (svc == drop_slot && svc + SC < err_from) err_from = svc + SC;
      exp_q.push_back(e);
      op_a_exp[svc] = a;
      op_b_exp[svc] = b;
      acc_cyc[i]    = cyc;
      busy_until[i] = svc + SC;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clear_inputs();
    model_clear();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int base;
    int ea;
    int eb;
    int id;
    int idx;
    if (rst && rst_q) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'(2'b11));
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
      chk("rst_resp_product", 32'(bus.resp_product), 32'(0));
      chk("rst_mult_start", 32'(bus.mult_start), 32'(0));
      chk("rst_operand_a", 32'(bus.mult_multiplier), 32'(0));
      chk("rst_operand_b", 32'(bus.mult_multiplicand), 32'(0));
      chk("rst_err_overrun", 32'(bus.err_overrun), 32'(0));
    end else if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        chk("req_ready", 32'(bus.req_ready[i]), 32'(model_ready(i, cyc)));
      chk("mult_start", 32'(bus.mult_start), 32'(cyc % SC == 0));
      base = cyc - (cyc % SC);
      ea = op_a_exp.exists(base) ? op_a_exp[base] : 0;
      eb = op_b_exp.exists(base) ? op_b_exp[base] : 0;
      chk("operand_a", 32'(bus.mult_multiplier), 32'(ea));
      chk("operand_b", 32'(bus.mult_multiplicand), 32'(eb));
      if (bus.resp_valid != '0) begin
        chk("resp_onehot", 32'($onehot(bus.resp_valid)), 32'(1));
        id = -1;
        for (int i = 0; i < NUM_REQ; i++)
          if (bus.resp_valid == NUM_REQ'(1 << i)) id = i;
        idx = -1;
        for (int k = exp_q.size() - 1; k >= 0; k--)
          if (exp_q[k].id == id) idx = k;
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp cycle=%0d got resp_valid=%0b want none",
                   cyc, bus.resp_valid);
        end else begin
          chk("resp_product", 32'(bus.resp_product), 32'(exp_q[idx].prod));
          chk("resp_cycle", 32'(cyc), 32'(exp_q[idx].cyc));
          exp_q.delete(idx);
        end
      end else begin
        chk("idle_product", 32'(bus.resp_product), 32'(0));
      end
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (exp_q[k].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_resp cycle=%0d got nothing want req%0d product %0d at %0d",
                   cyc, exp_q[k].id, exp_q[k].prod, exp_q[k].cyc);
          exp_q.delete(k);
        end
      end
      chk("err_overrun", 32'(bus.err_overrun), 32'(cyc >= err_from));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got no finish want finish", cyc);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    model_clear();

    // Reset and idle schedule: dummies only, no responses.
    do_reset(3);
    idle(40);

    // Single request from requester 0.
    do_reset(3);
    idle(5);
    offer(0, 13, 11);
    tick();
    idle(40);

    // Same request while requester 1 hammers 255x255.
    do_reset(3);
    for (int c = 0; c < 100; c++) begin
      offer(1, 255, 255);
      if (c == 5) offer(0, 13, 11);
      tick();
    end
    idle(30);

    // Simultaneous requests.
    do_reset(3);
    idle(2);
    offer(0, 0, 200);
    offer(1, 255, 255);
    tick();
    idle(40);

    // Request landing on the edge ending cycle 0 of its own slot.
    do_reset(3);
    idle(12);
    offer(1, 7, 9);
    tick();
    idle(40);

    // Suppressed productDone: zero product and sticky overrun.
    do_reset(3);
    drop_slot = 24;
    idle(5);
    offer(0, 13, 11);
    tick();
    idle(60);

    // Reset with an operation in flight: no response, schedule restarts.
    do_reset(3);
    idle(5);
    offer(0, 13, 11);
    tick();
    idle(24);
    do_reset(2);
    idle(40);

    // Random traffic.
    do_reset(3);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 1) == 1)
          offer(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      tick();
    end
    idle(40);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
